// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg                                                                  |
// | Shared state encodings, ACK/NACK levels and address helper for the       |
// | I2C responder.                                                           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b0000001,
    ST_DEV_ADDR  = 7'b0000010,
    ST_ADDR_H    = 7'b0000100,
    ST_ADDR_L    = 7'b0001000,
    ST_WR_DATA   = 7'b0010000,
    ST_RD_DATA   = 7'b0100000,
    ST_WAIT_STOP = 7'b1000000
  } state_e;

  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'b1010000;

  // In 8-bit mode the pointer wraps inside the low byte; the high byte stays 0.
  function automatic logic [15:0] next_addr(input logic [15:0] addr, input logic addr16);
    logic [7:0] lo_inc;
    lo_inc = addr[7:0] + 8'd1;
    return addr16 ? (addr + 16'd1) : {8'h00, lo_inc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_slave_dri_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_slave_dri_if                                                         |
// | SCL input, memory port and busy flag of the I2C responder.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface i2c_slave_dri_if;
  logic        scl;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        busy;

  modport slave (
    input  scl, mem_rd_data,
    output mem_addr, mem_wr_en, mem_wr_data, mem_rd_en, busy
  );

  modport master (
    output scl, mem_rd_data,
    input  mem_addr, mem_wr_en, mem_wr_data, mem_rd_en, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_bus_sync                                                             |
// | SCL/SDA synchronizer, optional glitch filter (I2C_SLAVE_GLITCH_FILTER_EN)|
// | and START/STOP/edge detection.                                           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module i2c_bus_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic scl_i,
  input  wire logic sda_i,
  output logic      sda_s,
  output logic      scl_rise,
  output logic      scl_fall,
  output logic      start_det,
  output logic      stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_c, sda_c;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

  // The filtered level only moves once three consecutive samples agree.
  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_flt_d  = scl_flt_q;
    sda_flt_d  = sda_flt_q;
    if (&{scl_hist_q, scl_sync_q[1]})       scl_flt_d = 1'b1;
    else if (~|{scl_hist_q, scl_sync_q[1]}) scl_flt_d = 1'b0;
    if (&{sda_hist_q, sda_sync_q[1]})       sda_flt_d = 1'b1;
    else if (~|{sda_hist_q, sda_sync_q[1]}) sda_flt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_s     = sda_c;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_dri.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_slave_dri                                                            |
// | I2C responder exposing a byte-wide memory port; optional input glitch    |
// | filter selected by I2C_SLAVE_GLITCH_FILTER_EN.                           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module i2c_slave_dri
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter bit         ADDR_16BIT = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  inout  wire           sda,
  i2c_slave_dri_if.slave bus
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, wr_data_q, wr_data_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        sda_out_q, sda_out_d, ack_q, ack_d, busy_q, busy_d;
  logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_cap_q, rd_cap_d;
  logic [7:0]  rx_byte;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (bus.scl),
    .sda_i     (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      wr_data_q  <= 8'h00;
      mem_addr_q <= 16'h0000;
      sda_out_q  <= NACK;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_cap_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      wr_data_q  <= wr_data_d;
      mem_addr_q <= mem_addr_d;
      sda_out_q  <= sda_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_cap_q   <= rd_cap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    wr_data_d  = wr_data_q;
    mem_addr_d = mem_addr_q;
    sda_out_d  = sda_out_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_cap_d   = rd_en_q;
    rx_byte    = {rx_q[6:0], sda_s};

    // Read data arrives one cycle after the request.
    if (rd_cap_q) tx_d = bus.mem_rd_data;
    if (wr_en_q)  mem_addr_d = next_addr(mem_addr_q, ADDR_16BIT);

    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_out_d = NACK;
      ack_d     = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_out_d = NACK;
      ack_d     = 1'b0;
    end else if (state_q != ST_IDLE && state_q != ST_WAIT_STOP) begin
      if (scl_rise) begin
        if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd0;
          ack_d     = 1'b0;
          // ack_q still set means this slot was our own address ACK.
          if (state_q == ST_RD_DATA) begin
            if (ack_q) begin
              rd_en_d = 1'b1;
            end else if (sda_s == ACK) begin
              mem_addr_d = next_addr(mem_addr_q, ADDR_16BIT);
              rd_en_d    = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end else begin
          rx_d      = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              ST_DEV_ADDR: begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  ack_d   = 1'b1;
                  busy_d  = 1'b1;
                  state_d = rx_byte[0] ? ST_RD_DATA : (ADDR_16BIT ? ST_ADDR_H : ST_ADDR_L);
                end else begin
                  busy_d  = 1'b0;
                  state_d = ST_WAIT_STOP;
                end
              end
              ST_ADDR_H: begin
                ack_d            = 1'b1;
                mem_addr_d[15:8] = rx_byte;
                state_d          = ST_ADDR_L;
              end
              ST_ADDR_L: begin
                ack_d      = 1'b1;
                mem_addr_d = {(ADDR_16BIT ? mem_addr_q[15:8] : 8'h00), rx_byte};
                state_d    = ST_WR_DATA;
              end
              ST_WR_DATA: begin
                ack_d     = 1'b1;
                wr_en_d   = 1'b1;
                wr_data_d = rx_byte;
              end
              default: ;
            endcase
          end
        end
      end else if (scl_fall) begin
        if (bit_cnt_q == 4'd8)
          sda_out_d = ack_q ? ACK : NACK;
        else if (state_q == ST_RD_DATA)
          sda_out_d = tx_q[3'd7 - bit_cnt_q[2:0]];
        else
          sda_out_d = NACK;
      end
    end
  end

  assign sda             = (sda_out_q == ACK) ? 1'b0 : 1'bz;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_dri.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_slave_dri                                                         |
// | Directed bench: one 16-bit-address responder (0x50) and one 8-bit one    |
// | (0x52) share the bus; memory traffic is checked against a scoreboard.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_i2c_slave_dri;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_dri_if if16 ();
  i2c_slave_dri_if if8 ();
  assign if16.scl = scl_m;
  assign if8.scl  = scl_m;

  i2c_slave_dri #(.SLAVE_ADDR(7'h50), .ADDR_16BIT(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .sda(sda), .bus(if16)
  );
  i2c_slave_dri #(.SLAVE_ADDR(7'h52), .ADDR_16BIT(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .sda(sda), .bus(if8)
  );

  int total = 0;
  int bad = 0;
  int wr16_n = 0, wr8_n = 0, rd16_n = 0, rd8_n = 0;
  logic [23:0] wr16_q[$], wr8_q[$];
  logic [15:0] rd16_q[$];
  logic [7:0]  seq_q[$];
  logic        ack;
  logic [7:0]  rbyte;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return (a == 16'h0010) ? 8'h5A : (a[7:0] ^ 8'hC3);
  endfunction

  // Memory model: data valid only in the cycle after the read strobe.
  always @(posedge clk) begin
    if16.mem_rd_data <= if16.mem_rd_en ? mem_val(if16.mem_addr) : 8'h00;
    if8.mem_rd_data  <= if8.mem_rd_en  ? mem_val(if8.mem_addr)  : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if16.mem_wr_en) begin
        wr16_n++;
        if (wr16_q.size() == 0) chk("wr16_extra", {if16.mem_addr, if16.mem_wr_data}, 32'hFFFFFFFF);
        else chk("wr16", {if16.mem_addr, if16.mem_wr_data}, {8'h00, wr16_q.pop_front()});
      end
      if (if8.mem_wr_en) begin
        wr8_n++;
        if (wr8_q.size() == 0) chk("wr8_extra", {if8.mem_addr, if8.mem_wr_data}, 32'hFFFFFFFF);
        else chk("wr8", {if8.mem_addr, if8.mem_wr_data}, {8'h00, wr8_q.pop_front()});
      end
      if (if16.mem_rd_en) begin
        rd16_n++;
        if (rd16_q.size() == 0) chk("rd16_extra", if16.mem_addr, 32'hFFFFFFFF);
        else chk("rd16_addr", if16.mem_addr, rd16_q.pop_front());
      end
      if (if8.mem_rd_en) begin
        rd8_n++;
        chk("rd8_extra", if8.mem_addr, 32'hFFFFFFFF);
      end
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_low = 1'b1; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_low = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0; wq();
    scl_m = 1'b1; wq();
    a = sda; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wq(); scl_m = 1'b1; wq();
      b[i] = sda; wq();
      scl_m = 1'b0; wq();
    end
    send_bit(mack);
    sda_low = 1'b0;
  endtask

  task automatic send_all(input string tag);
    logic a;
    for (int i = 0; i < seq_q.size(); i++) begin
      write_byte(seq_q[i], a);
      chk($sformatf("%s_ack%0d", tag, i), a, ACK);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", if16.mem_addr, 16'h0000);
    chk("rst_busy", if16.busy, 1'b0);
    chk("rst_wr_en", if16.mem_wr_en, 1'b0);
    chk("rst_wr_data", if16.mem_wr_data, 8'h00);
    chk("rst_rd_en", if16.mem_rd_en, 1'b0);
    chk("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    wq();

    // 16-bit write of two bytes.
    wr16_q.push_back({16'h0010, 8'hAB});
    wr16_q.push_back({16'h0011, 8'hCD});
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h10, 8'hAB, 8'hCD};
    send_all("wr");
    chk("wr_busy_in_txn", if16.busy, 1'b1);
    chk("wr_addr_after", if16.mem_addr, 16'h0012);
    i2c_stop(); wq();
    chk("wr_busy_after_stop", if16.busy, 1'b0);
    chk("wr_count", wr16_n, 2);

    // Random read of one byte.
    rd16_n = 0;
    rd16_q.push_back(16'h0010);
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h10};
    send_all("rr");
    i2c_start();
    write_byte(8'hA1, ack);
    chk("rr_dev_ack", ack, ACK);
    read_byte(NACK, rbyte);
    chk("rr_data", rbyte, 8'h5A);
    i2c_stop(); wq();
    chk("rr_addr", if16.mem_addr, 16'h0010);
    chk("rr_count", rd16_n, 1);

    // Unmatched address is ignored until the next START.
    i2c_start();
    write_byte(8'hA2, ack);
    chk("bad_addr_nack", ack, NACK);
    chk("bad_addr_busy", if16.busy, 1'b0);
    write_byte(8'h55, ack);
    chk("bad_addr_data_nack", ack, NACK);
    i2c_stop(); wq();

    // Sequential read of three bytes.
    rd16_n = 0;
    rd16_q.push_back(16'h0080);
    rd16_q.push_back(16'h0081);
    rd16_q.push_back(16'h0082);
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h80};
    send_all("sr");
    i2c_start();
    write_byte(8'hA1, ack);
    chk("sr_dev_ack", ack, ACK);
    read_byte(ACK, rbyte);
    chk("sr_data0", rbyte, 8'h43);
    read_byte(ACK, rbyte);
    chk("sr_data1", rbyte, 8'h42);
    read_byte(NACK, rbyte);
    chk("sr_data2", rbyte, 8'h41);
    wq(); wq();
    chk("sr_sda_released", sda, 1'b1);
    i2c_stop(); wq();
    chk("sr_count", rd16_n, 3);
    chk("sr_addr", if16.mem_addr, 16'h0082);

    // 8-bit address device: pointer wraps FF -> 00.
    wr8_q.push_back({16'h00FF, 8'h11});
    wr8_q.push_back({16'h0000, 8'h22});
    i2c_start();
    seq_q = '{8'hA4, 8'hFF, 8'h11, 8'h22};
    send_all("w8");
    i2c_stop(); wq();
    chk("w8_count", wr8_n, 2);
    chk("w8_addr", if8.mem_addr, 16'h0001);

    // Reset in the middle of a data byte.
    wr16_n = 0;
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h30};
    send_all("rs");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("rs_busy_before", if16.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_sda", sda, 1'b1);
    chk("rs_busy", if16.busy, 1'b0);
    chk("rs_addr", if16.mem_addr, 16'h0000);
    wq();
    rst_n = 1'b1;
    i2c_stop(); wq();
    wr16_q.push_back({16'h0040, 8'h77});
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h40, 8'h77};
    send_all("rs2");
    i2c_stop(); wq();
    chk("rs_write_count", wr16_n, 1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // A 2-clk SCL pulse inside a data byte must not shift a bit.
    wr16_q.push_back({16'h0050, 8'h81});
    i2c_start();
    seq_q = '{8'hA0, 8'h00, 8'h50};
    send_all("gl");
    send_bit(1'b1);
    wq();
    scl_m = 1'b1;
    repeat (2) @(posedge clk);
    #1 scl_m = 1'b0;
    for (int i = 6; i >= 0; i--) send_bit(i == 0);
    sda_low = 1'b0; wq();
    scl_m = 1'b1; wq();
    ack = sda; wq();
    scl_m = 1'b0; wq();
    chk("gl_ack", ack, ACK);
    i2c_stop(); wq();
`endif

    chk("wr16_q_empty", wr16_q.size(), 0);
    chk("wr8_q_empty", wr8_q.size(), 0);
    chk("rd16_q_empty", rd16_q.size(), 0);
    chk("rd8_none", rd8_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
